// File: rtl/rca_pkg.sv
// Shared types for the shared-rca arbiter slice.
// FSM state encoding and requester-ID width helper.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_e;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rca.sv
// Ripple-carry adder, purely combinational.
// Sum is width+1 bits with the carry-out in the MSB.
module rca #(
  parameter int width = 8
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width:0]   sum_o
);

  logic [width:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    for (int i = 0; i < width; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) |
                 (c[i] & (a_i[i] ^ b_i[i]));
    end
    sum_o[width] = c[width];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or
// above the pointer, wrapping, as one-hot plus index.
module rr_arbiter
  import rca_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  int k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr_i) + i) % N_REQ;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/rca_share_arbiter.sv
// Shares one rca between N_REQ requesters: round-robin
// grant, operand capture, settle wait, tagged response.
module rca_share_arbiter
  import rca_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*WIDTH-1:0]   req_a_i,
  input  logic [N_REQ*WIDTH-1:0]   req_b_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH:0]           rsp_sum_o,
  output logic [id_w(N_REQ)-1:0]   rsp_id_o,
  output logic                     busy_o
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH:0]    sum_q, sum_d;
  logic              vld_q, vld_d;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   win;
  logic              any;
  logic [WIDTH:0]    rca_sum;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any)
  );

  rca #(
    .width (WIDTH)
  ) u_rca (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (rca_sum)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    vld_d       = vld_q;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        // Ready is masked during reset so no handshake is seen.
        if (!rst_i) req_ready_o = gnt;
        if (any) begin
          a_d     = req_a_i[int'(win)*WIDTH +: WIDTH];
          b_d     = req_b_i[int'(win)*WIDTH +: WIDTH];
          id_d    = win;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          sum_d   = rca_sum;
          vld_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          vld_d   = 1'b0;
          state_d = IDLE;
          if (id_q == ID_W'(N_REQ - 1)) ptr_d = '0;
          else                          ptr_d = id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      vld_q   <= vld_d;
    end
  end

  assign rsp_valid_o = vld_q;
  assign rsp_sum_o   = sum_q;
  assign rsp_id_o    = id_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Randomized bench for rca_share_arbiter with a
// transaction-level reference model and scoreboard.
module tb_rca_share_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_a_i;
  logic [N*W-1:0] req_b_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [W:0]     rsp_sum_o;
  logic [1:0]     rsp_id_o;
  logic           busy_o;

  rca_share_arbiter #(
    .WIDTH         (W),
    .N_REQ         (N),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_sum_o   (rsp_sum_o),
    .rsp_id_o    (rsp_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: transaction view, not RTL state.
  bit m_idle = 1'b1;
  bit m_resp = 1'b0;
  int m_left = 0;
  int m_ptr  = 0;
  int m_id   = 0;
  int m_a    = 0;
  int m_b    = 0;
  int id_q[$];
  int sum_q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v,
                              input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic int opa(input int k);
    return int'(req_a_i[k*W +: W]);
  endfunction

  function automatic int opb(input int k);
    return int'(req_b_i[k*W +: W]);
  endfunction

  // One cycle: inputs already set at negedge.
  task automatic tick();
    int w;
    logic [N-1:0] er;
    #1;
    w  = pick(req_valid_i, m_ptr);
    er = '0;
    if (!rst_i && m_idle && w >= 0) er[w] = 1'b1;
    check("ready", 32'(req_ready_o), 32'(er));
    check("valid", 32'(rsp_valid_o), 32'(m_resp));
    check("busy", 32'(busy_o), 32'(!m_idle));
    if (m_resp) begin
      check("sum", 32'(rsp_sum_o), 32'(m_a + m_b));
      check("id", 32'(rsp_id_o), 32'(m_id));
    end
    @(posedge clk_i);
    if (rst_i) begin
      m_idle = 1'b1;
      m_resp = 1'b0;
      m_ptr  = 0;
    end else if (m_idle) begin
      if (w >= 0) begin
        m_idle = 1'b0;
        m_left = S;
        m_id   = w;
        m_a    = opa(w);
        m_b    = opb(w);
      end
    end else if (!m_resp) begin
      m_left--;
      if (m_left == 0) m_resp = 1'b1;
    end else if (rsp_ready_i) begin
      $display("%d %d %d", m_a, m_b, m_a + m_b);
      id_q.push_back(m_id);
      sum_q.push_back(m_a + m_b);
      m_resp = 1'b0;
      m_idle = 1'b1;
      m_ptr  = (m_id + 1) % N;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst_i = 1'b0;
  endtask

  task automatic run_op(input int k, input int a,
                        input int b, input int exp);
    int n;
    req_valid_i = '0;
    req_valid_i[k] = 1'b1;
    req_a_i[k*W +: W] = W'(a);
    req_b_i[k*W +: W] = W'(b);
    rsp_ready_i = 1'b1;
    n = 0;
    tick();
    req_valid_i = '0;
    while (!rsp_valid_o && n < 20) begin
      tick();
      n++;
    end
    check("op_seen", 32'(rsp_valid_o), 32'd1);
    check("op_sum", 32'(rsp_sum_o), 32'(exp));
    check("op_id", 32'(rsp_id_o), 32'(k));
    tick();
    check("op_done", 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '1;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    do_reset(3);
    check("rst_sum", 32'(rsp_sum_o), 32'd0);
    req_valid_i = '0;
    tick();

    run_op(2, 200, 100, 300);
    run_op(1, 255, 255, 9'h1FE);
    run_op(3, 0, 0, 0);
    run_op(0, 255, 1, 9'h100);

    // Round robin from pointer 0.
    do_reset(1);
    id_q.delete();
    sum_q.delete();
    for (int k = 0; k < N; k++) begin
      req_a_i[k*W +: W] = W'(k);
      req_b_i[k*W +: W] = W'(1);
    end
    req_valid_i = '1;
    for (int i = 0; i < 5 * (S + 2); i++) tick();
    check("rr_cnt", 32'(id_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < id_q.size(); i++) begin
      check("rr_id", 32'(id_q[i]), 32'(i % N));
      check("rr_sum", 32'(sum_q[i]), 32'((i % N) + 1));
    end

    // Backpressure with all valids pending.
    rsp_ready_i = 1'b0;
    for (int i = 0; i < S + 6; i++) tick();
    check("bp_hold", 32'(rsp_valid_o), 32'd1);
    rsp_ready_i = 1'b1;
    tick();

    // Reset one cycle after grant.
    req_valid_i = 4'b0100;
    tick();
    tick();
    do_reset(1);
    check("mid_rst", 32'(rsp_valid_o), 32'd0);
    req_valid_i = '1;
    tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      req_valid_i = N'($urandom_range(0, 15));
      req_a_i     = $urandom;
      req_b_i     = $urandom;
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      rst_i       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
